// File: rtl/ether_tx_frame_gen.sv
// Ethernet test-frame writer for the MAC TX buffer: software header plus a
// sequence-numbered counting payload, pushed one word at a time under READY/FULL.
module ether_tx_frame_gen #(
    parameter int MIN_PAYLOAD_WORDS = 11,
    parameter int MAX_PAYLOAD_WORDS = 374,
    parameter int GAP_CYCLES        = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [47:0] i_dest_mac,
    input  logic [47:0] i_mac_address,
    input  logic [15:0] i_ether_type,
    input  logic [10:0] i_payload_words,
    input  logic [15:0] i_frame_count,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_seq_no,
    output logic        o_tx_buff_we,
    output logic        o_tx_buff_start,
    output logic        o_tx_buff_end,
    output logic [31:0] o_tx_buff_data,
    input  logic        i_tx_buff_ready,
    input  logic        i_tx_buff_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_HDR,
        S_PAY,
        S_GAP,
        S_FINISH
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_arm;
    logic [47:0] r_dest;
    logic [47:0] r_src;
    logic [15:0] r_type;
    logic [15:0] r_count;
    logic [15:0] r_frames;
    logic [15:0] r_seq;
    logic [10:0] r_n;
    logic [10:0] r_idx;
    logic [15:0] r_gap;
    logic        r_valid;
    logic        r_first;
    logic        r_last;
    logic [31:0] r_data;

    logic        w_accept;
    logic        w_start_run;
    logic        w_load;
    logic        w_gap_done;
    logic        w_run_over;
    logic [10:0] w_n_clamped;
    logic [10:0] w_next_idx;
    logic [15:0] w_pay_k;
    logic [31:0] w_next_data;

    // A word is held in r_data while r_valid; FULL only masks the strobe.
    assign w_accept    = r_valid & ~i_tx_buff_full;
    assign w_start_run = (r_state == S_IDLE) & i_start & r_arm;
    assign w_load      = (r_state == S_WAIT_RDY) & ~i_stop & i_tx_buff_ready;
    assign w_gap_done  = (r_state == S_GAP) && (r_gap == 16'(GAP_CYCLES - 1));
    assign w_run_over  = i_stop | ((r_count != 16'd0) && (r_frames == r_count));

    assign o_tx_buff_we    = w_accept;
    assign o_tx_buff_start = r_first & w_accept;
    assign o_tx_buff_end   = r_last & w_accept;
    assign o_tx_buff_data  = r_data;
    assign o_seq_no        = r_seq;
    assign o_busy          = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign o_done          = (r_state == S_FINISH);

    always_comb begin
        w_n_clamped = i_payload_words;
        if (i_payload_words < 11'(MIN_PAYLOAD_WORDS)) begin
            w_n_clamped = 11'(MIN_PAYLOAD_WORDS);
        end else if (i_payload_words > 11'(MAX_PAYLOAD_WORDS)) begin
            w_n_clamped = 11'(MAX_PAYLOAD_WORDS);
        end
    end

    always_comb begin
        w_next_idx = w_load ? 11'd0 : r_idx + 11'd1;
        w_pay_k    = 16'(w_next_idx - 11'd4);
        case (w_next_idx)
            11'd0:   w_next_data = r_dest[47:16];
            11'd1:   w_next_data = {r_dest[15:0], r_src[47:32]};
            11'd2:   w_next_data = r_src[31:0];
            11'd3:   w_next_data = {r_type, r_seq};
            default: w_next_data = {r_seq, w_pay_k};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_run) w_state_next = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (i_stop) w_state_next = S_FINISH;
                else if (i_tx_buff_ready) w_state_next = S_HDR;
            end
            S_HDR: begin
                if (w_accept && (r_idx == 11'd3)) w_state_next = S_PAY;
            end
            S_PAY: begin
                if (w_accept && r_last) w_state_next = S_GAP;
            end
            S_GAP: begin
                if (w_gap_done) w_state_next = w_run_over ? S_FINISH : S_WAIT_RDY;
            end
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // r_arm blocks a START sampled on the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arm    <= 1'b0;
            r_dest   <= '0;
            r_src    <= '0;
            r_type   <= '0;
            r_count  <= '0;
            r_frames <= '0;
            r_seq    <= '0;
            r_n      <= '0;
            r_idx    <= '0;
            r_gap    <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_arm <= 1'b1;
            if (w_start_run) begin
                r_dest   <= i_dest_mac;
                r_src    <= i_mac_address;
                r_type   <= i_ether_type;
                r_count  <= i_frame_count;
                r_n      <= w_n_clamped;
                r_seq    <= 16'd0;
                r_frames <= 16'd0;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_idx   <= 11'd0;
                r_data  <= w_next_data;
                r_first <= 1'b1;
                r_last  <= 1'b0;
            end else if (w_accept) begin
                if (r_last) begin
                    r_valid  <= 1'b0;
                    r_first  <= 1'b0;
                    r_last   <= 1'b0;
                    r_seq    <= r_seq + 16'd1;
                    r_frames <= r_frames + 16'd1;
                    r_gap    <= 16'd0;
                end else begin
                    r_idx   <= w_next_idx;
                    r_data  <= w_next_data;
                    r_first <= 1'b0;
                    r_last  <= (w_next_idx == r_n + 11'd3);
                end
            end
            if (r_state == S_GAP) begin
                r_gap <= r_gap + 16'd1;
            end
        end
    end

endmodule
